// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder/regfile side in, EX-facing registered side out.
// master = upstream/downstream environment, slave = the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [31:0]       Instruction_ID;
    logic [DATA_W-1:0] PC4_ID;
    logic [DATA_W-1:0] ReadData1_ID;
    logic [DATA_W-1:0] ReadData2_ID;
    logic              RegWrite_ID;
    logic              MemtoReg_ID;
    logic              Branch_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic              RegDst_ID;
    logic              ALUSrc_ID;
    logic [1:0]        ALUOp_ID;
    logic              Valid_ID;
    logic              Stall_EX;
    logic              Flush_EX;

    logic              RegWrite_EX;
    logic              MemtoReg_EX;
    logic              Branch_EX;
    logic              MemRead_EX;
    logic              MemWrite_EX;
    logic              RegDst_EX;
    logic              ALUSrc_EX;
    logic [1:0]        ALUOp_EX;
    logic [DATA_W-1:0] ReadData1_EX;
    logic [DATA_W-1:0] ReadData2_EX;
    logic [DATA_W-1:0] PC4_EX;
    logic [DATA_W-1:0] SignExt_EX;
    logic [REG_AW-1:0] Rs_EX;
    logic [REG_AW-1:0] Rt_EX;
    logic [REG_AW-1:0] Rd_EX;
    logic [5:0]        Funct_EX;
    logic              Valid_EX;
    logic              Stall_ID;

    modport master (
        output Instruction_ID, PC4_ID, ReadData1_ID, ReadData2_ID,
        output RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID,
        output MemWrite_ID, RegDst_ID, ALUSrc_ID, ALUOp_ID,
        output Valid_ID, Stall_EX, Flush_EX,
        input  RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX,
        input  MemWrite_EX, RegDst_EX, ALUSrc_EX, ALUOp_EX,
        input  ReadData1_EX, ReadData2_EX, PC4_EX, SignExt_EX,
        input  Rs_EX, Rt_EX, Rd_EX, Funct_EX, Valid_EX, Stall_ID
    );

    modport slave (
        input  Instruction_ID, PC4_ID, ReadData1_ID, ReadData2_ID,
        input  RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID,
        input  MemWrite_ID, RegDst_ID, ALUSrc_ID, ALUOp_ID,
        input  Valid_ID, Stall_EX, Flush_EX,
        output RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX,
        output MemWrite_EX, RegDst_EX, ALUSrc_EX, ALUOp_EX,
        output ReadData1_EX, ReadData2_EX, PC4_EX, SignExt_EX,
        output Rs_EX, Rt_EX, Rd_EX, Funct_EX, Valid_EX, Stall_ID
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS32 ID/EX pipeline register with hold, flush-to-bubble and valid tag.
// Define ID_EX_LOADUSE_EN to add load-use hazard detection and ID stall.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_dst;
        logic              alu_src;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] sext;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [5:0]        funct;
        logic              valid;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_d;
    ex_t  cap;
    logic hazard;

    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic [REG_AW-1:0] rd_id;
    logic [15:0]       imm_id;

    assign rs_id  = bus.Instruction_ID[21 +: REG_AW];
    assign rt_id  = bus.Instruction_ID[16 +: REG_AW];
    assign rd_id  = bus.Instruction_ID[11 +: REG_AW];
    assign imm_id = bus.Instruction_ID[15:0];

    // AND-gating forces 0 even when the decoder leaves a don't-care as X
    always_comb begin
        logic vld;
        logic rw;
        cap        = '0;
        vld        = bus.Valid_ID;
        rw         = vld & bus.RegWrite_ID;
        cap.valid      = vld;
        cap.reg_write  = rw;
        cap.mem_to_reg = rw & bus.MemtoReg_ID;
        cap.reg_dst    = rw & bus.RegDst_ID;
        cap.branch     = vld & bus.Branch_ID;
        cap.mem_read   = vld & bus.MemRead_ID;
        cap.mem_write  = vld & bus.MemWrite_ID;
        cap.alu_src    = vld & bus.ALUSrc_ID;
        cap.alu_op     = {2{vld}} & bus.ALUOp_ID;
        cap.rd1        = bus.ReadData1_ID;
        cap.rd2        = bus.ReadData2_ID;
        cap.pc4        = bus.PC4_ID;
        cap.sext       = {{(DATA_W-16){imm_id[15]}}, imm_id};
        cap.rs         = rs_id;
        cap.rt         = rt_id;
        cap.rd         = rd_id;
        cap.funct      = bus.Instruction_ID[5:0];
    end

`ifdef ID_EX_LOADUSE_EN
    logic [5:0] opcode_id;
    logic       rt_read;
    logic       match;

    assign opcode_id = bus.Instruction_ID[31:26];

    // R-type, SW and BEQ are the opcodes that actually read rt
    always_comb begin
        rt_read = (opcode_id == 6'b000000)
                | (opcode_id == 6'b101011)
                | (opcode_id == 6'b000100);
        match   = (ex_q.rt == rs_id)
                | ((ex_q.rt == rt_id) & rt_read);
        hazard  = ex_q.valid & ex_q.mem_read & ex_q.reg_write
                & (ex_q.rt != '0) & bus.Valid_ID & match;
    end
`else
    logic unused_opcode;
    assign unused_opcode = ^bus.Instruction_ID[31:26];
    assign hazard        = 1'b0;
`endif

    always_comb begin
        ex_d = ex_q;
        priority case (1'b1)
            bus.Flush_EX: ex_d = '0;
            bus.Stall_EX: ex_d = ex_q;
            hazard:       ex_d = '0;
            default:      ex_d = cap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.RegWrite_EX  = ex_q.reg_write;
    assign bus.MemtoReg_EX  = ex_q.mem_to_reg;
    assign bus.Branch_EX    = ex_q.branch;
    assign bus.MemRead_EX   = ex_q.mem_read;
    assign bus.MemWrite_EX  = ex_q.mem_write;
    assign bus.RegDst_EX    = ex_q.reg_dst;
    assign bus.ALUSrc_EX    = ex_q.alu_src;
    assign bus.ALUOp_EX     = ex_q.alu_op;
    assign bus.ReadData1_EX = ex_q.rd1;
    assign bus.ReadData2_EX = ex_q.rd2;
    assign bus.PC4_EX       = ex_q.pc4;
    assign bus.SignExt_EX   = ex_q.sext;
    assign bus.Rs_EX        = ex_q.rs;
    assign bus.Rt_EX        = ex_q.rt;
    assign bus.Rd_EX        = ex_q.rd;
    assign bus.Funct_EX     = ex_q.funct;
    assign bus.Valid_EX     = ex_q.valid;
    assign bus.Stall_ID     = rst_n & (bus.Stall_EX | hazard);
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary for the 5-stage MIPS32 datapath. Sits directly downstream of the ID control decoder and register file, and feeds the EX stage (ALU control, ALU source mux, RegDst mux).
- Registers the decoded control set, operands, sign-extended immediate and register specifiers.
- Supports hold (stall), bubble injection (flush) and a valid tag. Optionally detects load-use hazards and requests an ID/IF stall.

Parameters:
- DATA_W, 32, width of operand and PC+4 datapath
- REG_AW, 5, register-specifier width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Instruction_ID  in  32  instruction in ID; fields [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm, [5:0] funct, [31:26] opcode
- PC4_ID  in  DATA_W  PC+4 of the ID instruction
- ReadData1_ID, ReadData2_ID  in  DATA_W  register file read ports
- RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID  in  1 each  decoder controls
- ALUOp_ID  in  2  decoder ALU op
- Valid_ID  in  1  ID holds a real instruction
- Stall_EX  in  1  downstream hold request (e.g. memory wait)
- Flush_EX  in  1  kill the instruction entering EX (branch taken)
- RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX, ALUSrc_EX  out  1 each  registered controls
- ALUOp_EX  out  2  registered ALU op
- ReadData1_EX, ReadData2_EX, PC4_EX, SignExt_EX  out  DATA_W  registered operands; SignExt_EX = imm sign-extended to DATA_W
- Rs_EX, Rt_EX, Rd_EX  out  REG_AW  registered specifiers
- Funct_EX  out  6  registered funct field
- Valid_EX  out  1  EX holds a real instruction
- Stall_ID  out  1  combinational; upstream (PC, IF/ID) must hold when 1

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs are 0, Valid_EX=0. Stall_ID=0 while in reset.
- Per-edge update priority, highest first:
  1. Flush_EX=1: load a bubble. All control outputs 0, Valid_EX=0, data/specifier outputs 0.
  2. Stall_EX=1: hold every register unchanged.
  3. Load-use hazard (optional feature only): load a bubble, same as flush.
  4. Otherwise: capture all ID inputs. Valid_EX=Valid_ID.
- Flush and Stall_EX in the same cycle: the flush wins and the EX contents are replaced by a bubble.
- Valid_ID=0 on a normal load: controls are captured as 0 (bubble), regardless of the decoder outputs.
- X sanitising:
  - When RegWrite_ID=0, RegDst_EX and MemtoReg_EX are registered as 0. This covers SW and BEQ, whose decoder outputs are don't-care.
  - No output may be X after reset.
- Latency: 1 cycle from ID inputs to EX outputs. There are no internal states beyond the pipeline register and the valid bit.
- Stall_ID = Stall_EX OR hazard. It is purely combinational from current EX registers and ID inputs, with no registered delay.
- Mid-operation reset: the pipeline is cleared immediately and Stall_ID drops.

Optional Feature:
- Macro ID_EX_LOADUSE_EN.
- Defined:
  - hazard = Valid_EX & MemRead_EX & RegWrite_EX & (Rt_EX != 0) & Valid_ID & match.
  - match = (Rt_EX == rs_ID) OR (Rt_EX == rt_ID AND opcode_ID is R-type 000000, SW 101011 or BEQ 000100).
  - On hazard (without flush or Stall_EX), EX loads a bubble and Stall_ID=1 for exactly one cycle.
  - Next cycle the dependent instruction enters EX normally.
- Undefined: hazard is constant 0, Stall_ID = Stall_EX, and no bubble is generated internally.

Test Plan:
- Reset, then LW r2,8(r1) (0x8C220008) with Valid_ID=1, PC4_ID=0x4 → next edge: MemRead_EX=1, RegWrite_EX=1, MemtoReg_EX=1, ALUSrc_EX=1, ALUOp_EX=00, Rt_EX=2, SignExt_EX=0x00000008, Valid_EX=1.
- Imm 0xFFF0 in an SW instruction → SignExt_EX=0xFFFFFFF0, MemWrite_EX=1, RegDst_EX=0, MemtoReg_EX=0 (no X).
- R-type in EX with Stall_EX=1 for 3 cycles while ID inputs change → EX outputs constant for 3 edges, Stall_ID=1 throughout.
- Flush_EX=1 and Stall_EX=1 in the same cycle with BEQ in ID → next edge: all controls 0, Valid_EX=0.
- (ID_EX_LOADUSE_EN) LW r2 in EX, ADD r3,r2,r4 (0x00441820) in ID → Stall_ID=1 for one cycle, EX gets a bubble, then ADD enters EX with RegDst_EX=1, ALUOp_EX=10. Repeat with LW to r0 → no stall.
- Assert rst_n=0 asynchronously mid-cycle while Valid_EX=1 → outputs clear before the next clock edge.
